fir_tap_scheduler: RTL and testbench

Time-multiplexed sequencer for the 5-tap shift-add FIR. It owns the sample delay line and accumulator. It schedules one shared 16-bit adder, an external instance of exact or approximate prefix type, once per tap instead of using four adders in a chain. Samples enter and results leave through valid/ready handshakes, so the block sits between the sample source and the filter-output consumer.

---
 rtl/fir_tap_scheduler.sv | 141 ++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_scheduler
// Brief    : Time-multiplexed 5-tap shift-add FIR sequencer driving one shared
//            external adder, with valid/ready sample input and result output.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_scheduler #(
    parameter int DW    = 16,
    parameter int NTAPS = 5,
    parameter int SH0   = 5,
    parameter int SH1   = 4,
    parameter int SH2   = 3,
    parameter int SH3   = 2,
    parameter int SH4   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] x,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    output logic          add_en,
    input  logic [DW-1:0] add_sum,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_TAP = 3'(NTAPS - 1);

    state_t        state_q, state_d;
    logic [2:0]    tap_q, tap_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] dataout_q, dataout_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] d_q [NTAPS];
    logic [DW-1:0] d_d [NTAPS];

    logic [DW-1:0] w_shifted;
    logic          w_in_ready;
    logic          w_accept;

    always_comb begin
        w_shifted = '0;
        case (tap_q)
            3'd0:    w_shifted = d_q[0] >> SH0;
            3'd1:    w_shifted = d_q[1] >> SH1;
            3'd2:    w_shifted = d_q[2] >> SH2;
            3'd3:    w_shifted = d_q[3] >> SH3;
            3'd4:    w_shifted = d_q[4] >> SH4;
            default: w_shifted = '0;
        endcase
    end

    // A pending result blocks new samples unless the consumer takes it this cycle.
    assign w_in_ready = !rst && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && out_ready));
    assign w_accept   = w_in_ready && in_valid;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        dataout_d   = dataout_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = add_sum;
                tap_d = tap_q + 3'd1;
                if (tap_q == c_LAST_TAP) begin
                    tap_d       = '0;
                    dataout_d   = add_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = w_accept ? S_ACC : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_accept) begin
            d_d[0] = x;
            for (int k = 1; k < NTAPS; k++) begin
                d_d[k] = d_q[k-1];
            end
            acc_d = '0;
            tap_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign dataout   = dataout_q;
    assign out_valid = out_valid_q;
    assign add_en    = !rst && (state_q == S_ACC);
    assign add_a     = (state_q == S_ACC) ? acc_q     : '0;
    assign add_b     = (state_q == S_ACC) ? w_shifted : '0;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_scheduler
// Brief    : Self-checking bench for fir_tap_scheduler with exact and windowed
//            approximate shared adders and a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_tap_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_en;
    logic [15:0] add_sum;
    logic        busy;

    bit          use_apx = 1'b0;
    int          errors  = 0;
    int          checks  = 0;
    logic [15:0] hist [5];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    // Approximate adder: carry into bit i only sees the 6 bits below it.
    function automatic logic [15:0] apx_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        int          lo;
        int          n;
        int unsigned m;
        int unsigned w;
        for (int i = 0; i < 16; i++) begin
            lo   = (i > 6) ? i - 6 : 0;
            n    = i - lo;
            m    = (32'd1 << n) - 32'd1;
            w    = ((32'(a) >> lo) & m) + ((32'(b) >> lo) & m);
            s[i] = a[i] ^ b[i] ^ w[n];
        end
        return s;
    endfunction

    assign add_sum = use_apx ? apx_add(add_a, add_b) : 16'(add_a + add_b);

    fir_tap_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_sum   (add_sum),
        .busy      (busy)
    );

    function automatic logic [15:0] model_out(input bit apx);
        int          sh [5] = '{5, 4, 3, 2, 1};
        logic [15:0] s = 16'h0000;
        logic [15:0] m;
        for (int k = 0; k < 5; k++) begin
            m = hist[k] >> sh[k];
            s = apx ? apx_add(s, m) : 16'(s + m);
        end
        return s;
    endfunction

    task automatic model_push(input logic [15:0] xv);
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = xv;
        exp_q.push_back(model_out(use_apx));
    endtask

    task automatic model_clear();
        for (int k = 0; k < 5; k++) hist[k] = 16'h0000;
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        #1;
    endtask

    // Offers one sample and returns just after the accepting edge.
    task automatic accept_sample(input logic [15:0] xv, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        x        = xv;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            #1;
            n++;
        end
        ok = in_ready;
        if (ok) model_push(xv);
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (counted as 1) until out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        #1;
        while (!out_valid && lat < 30) begin
            tick();
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        x         = 16'hABCD;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || add_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b add_en=%b want 0 0", in_ready, add_en);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dataout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b busy=%b dataout=%h want 0 0 0000",
                     out_valid, busy, dataout);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        checks++;
        if (in_ready !== 1'b1 || add_en !== 1'b0 || add_a !== 16'h0 || add_b !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b add_en=%b add_a=%h add_b=%h want 1 0 0000 0000",
                     in_ready, add_en, add_a, add_b);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] smp [6] = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] tab [6] = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
        logic [15:0] tmp;
        bit          ok;
        int          lat;
        use_apx   = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            accept_sample(smp[i], ok);
            wait_result(lat);
            checks++;
            if (!ok || lat != 6) begin
                errors++;
                $display("FAIL impulse_latency[%0d]: accepted=%b latency=%0d want 1 6", i, ok, lat);
            end
            checks++;
            if (dataout !== tab[i]) begin
                errors++;
                $display("FAIL impulse_data[%0d]: got %h want %h", i, dataout, tab[i]);
            end
            if (exp_q.size() > 0) tmp = exp_q.pop_front();
            tick();
        end
    endtask

    task automatic test_constant();
        logic [15:0] tab [5] = '{16'h07FF, 16'h0FFF, 16'h1FFF, 16'h3FFF, 16'h7FFF};
        logic [15:0] tmp;
        bit          ok;
        int          lat;
        int          cnt = 0;
        use_apx   = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept_sample(16'hFFFF, ok);
            wait_result(lat);
            if (exp_q.size() > 0) tmp = exp_q.pop_front();
            tick();
        end
        accept_sample(16'hFFFF, ok);
        #1;
        for (int c = 0; c < 6; c++) begin
            if (add_en) cnt++;
            if (c < 5) begin
                checks++;
                if (add_b !== tab[c]) begin
                    errors++;
                    $display("FAIL const_add_b[%0d]: got %h want %h", c, add_b, tab[c]);
                end
            end
            if (c < 5) begin
                tick();
                #1;
            end
        end
        checks++;
        if (cnt != 5) begin
            errors++;
            $display("FAIL const_add_en_cycles: got %0d want 5", cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || dataout !== 16'hF7FB) begin
            errors++;
            $display("FAIL const_result: out_valid=%b dataout=%h want 1 f7fb", out_valid, dataout);
        end
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic [15:0] want;
        bit          ok;
        int          lat;
        use_apx   = 1'b0;
        do_reset();
        out_ready = 1'b0;
        accept_sample(16'h1234, ok);
        wait_result(lat);
        held = dataout;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (lat != 6 || held !== want) begin
            errors++;
            $display("FAIL bp_first: latency=%0d dataout=%h want 6 %h", lat, held, want);
        end
        in_valid = 1'b1;
        x        = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || dataout !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b dataout=%h in_ready=%b want 1 %h 0",
                         i, out_valid, dataout, in_ready, held);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dataout !== held) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b busy=%b dataout=%h want 0 0 %h",
                     out_valid, busy, dataout, held);
        end
        accept_sample(16'h0100, ok);
        wait_result(lat);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (dataout !== want) begin
            errors++;
            $display("FAIL bp_next: got %h want %h", dataout, want);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        int          last_acc = -1;
        int          nacc = 0;
        int          nres = 0;
        bit          took;
        use_apx   = 1'b0;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = 16'($urandom);
        #1;
        for (int cyc = 0; cyc < 62; cyc++) begin
            took = 1'b0;
            if (in_ready) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                model_push(x);
                nacc++;
                took = 1'b1;
            end
            if (out_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (dataout !== want) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", nres, dataout, want);
                end
                nres++;
            end
            tick();
            if (took) x = 16'($urandom);
            #1;
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (dataout !== want) begin
                    errors++;
                    $display("FAIL b2b_tail: got %h want %h", dataout, want);
                end
                nres++;
            end
            tick();
            #1;
        end
        checks++;
        if (nres != nacc) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d", nres, nacc);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] tmp;
        bit          ok;
        int          lat;
        use_apx   = 1'b0;
        do_reset();
        out_ready = 1'b1;
        accept_sample(16'h7000, ok);
        wait_result(lat);
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        tick();
        accept_sample(16'h1234, ok);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || add_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold: in_ready=%b add_en=%b want 0 0", in_ready, add_en);
        end
        tick();
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || add_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: busy=%b out_valid=%b add_en=%b want 0 0 0",
                     busy, out_valid, add_en);
        end
        accept_sample(16'h8000, ok);
        wait_result(lat);
        checks++;
        if (lat != 6 || dataout !== 16'h0400) begin
            errors++;
            $display("FAIL midrst_impulse: latency=%0d dataout=%h want 6 0400", lat, dataout);
        end
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        tick();
    endtask

    task automatic test_random_approx();
        logic [15:0] want;
        int          nacc = 0;
        int          nres = 0;
        int          cyc  = 0;
        bit          took;
        use_apx = 1'b1;
        do_reset();
        x = 16'($urandom);
        while ((nacc < 200 || nres < 200) && cyc < 5000) begin
            in_valid  = (nacc < 200) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            #1;
            took = 1'b0;
            if (in_valid && in_ready) begin
                model_push(x);
                nacc++;
                took = 1'b1;
            end
            if (out_valid && out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (dataout !== want) begin
                    errors++;
                    $display("FAIL apx_data[%0d]: got %h want %h", nres, dataout, want);
                end
                nres++;
            end
            tick();
            if (took) x = 16'($urandom);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (nacc != 200 || nres != 200) begin
            errors++;
            $display("FAIL apx_count: accepts=%0d results=%0d want 200 200", nacc, nres);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0000;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_constant();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_approx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
